// File: rtl/div_shift_seq.sv
// rtl/div_shift_seq.sv - iterative signed fixed-point divider, Q = (A << FRAC) / B, one quotient bit per clock (optional macro: DIV_ROUND_EN)
module div_shift_seq #(
    parameter int D_W  = 16,
    parameter int FRAC = 8
) (
    input  logic           I_CLK,
    input  logic           I_RST,
    input  logic           I_START,
    input  logic [D_W-1:0] I_DIVIDEND,
    input  logic [D_W-1:0] I_DIVISOR,
    output logic           O_BUSY,
    output logic           O_VALID,
    output logic [D_W-1:0] O_QUOT,
    output logic           O_DIV0,
    output logic           O_OVF
);

    localparam int N  = D_W + FRAC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Saturation limits expressed in the widened magnitude domain
    localparam logic [N:0]     NEG_LIM = (N+1)'(1) << (D_W - 1);
    localparam logic [N:0]     POS_LIM = NEG_LIM - (N+1)'(1);
    localparam logic [D_W-1:0] Q_MAX   = {1'b0, {(D_W-1){1'b1}}};
    localparam logic [D_W-1:0] Q_MIN   = {1'b1, {(D_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   num;
    logic [N-1:0]   quot;
    logic [D_W-1:0] rem;
    logic [D_W-1:0] b_mag;
    logic           neg_a;
    logic           neg_res;
    logic           b_zero;

    // Magnitudes are unsigned so the most negative operand is represented exactly
    logic [D_W-1:0] a_mag_in, b_mag_in;
    assign a_mag_in = I_DIVIDEND[D_W-1] ? (~I_DIVIDEND + 1'b1) : I_DIVIDEND;
    assign b_mag_in = I_DIVISOR[D_W-1]  ? (~I_DIVISOR  + 1'b1) : I_DIVISOR;

    // One restoring shift-subtract step
    logic [D_W:0] rem_sh, rem_sub;
    logic         rem_ge;
    always_comb begin
        rem_sh  = {rem, num[N-1]};
        rem_ge  = (rem_sh >= {1'b0, b_mag});
        rem_sub = rem_sh - {1'b0, b_mag};
    end

    // Final correction: optional rounding, then saturation and sign application
    logic [N:0]     mag_fix;
    logic [D_W-1:0] q_fix;
    logic           ovf_fix;
    always_comb begin
        mag_fix = {1'b0, quot};
`ifdef DIV_ROUND_EN
        if ({rem, 1'b0} >= {1'b0, b_mag})
            mag_fix = mag_fix + (N+1)'(1);
`endif
        q_fix   = '0;
        ovf_fix = 1'b0;
        if (b_zero) begin
            q_fix = neg_a ? Q_MIN : Q_MAX;
        end else if (neg_res) begin
            if (mag_fix > NEG_LIM) begin
                q_fix   = Q_MIN;
                ovf_fix = 1'b1;
            end else begin
                q_fix = D_W'(~mag_fix + (N+1)'(1));
            end
        end else begin
            if (mag_fix > POS_LIM) begin
                q_fix   = Q_MAX;
                ovf_fix = 1'b1;
            end else begin
                q_fix = mag_fix[D_W-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; starts outside IDLE are dropped, not queued
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (I_START) state_nx = CALC;
            CALC: if (cnt == CW'(N - 1)) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        O_BUSY  = (state == CALC) || (state == FIX);
        O_VALID = (state == DONE);
    end

    // Working registers and held result
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            cnt     <= '0;
            num     <= '0;
            quot    <= '0;
            rem     <= '0;
            b_mag   <= '0;
            neg_a   <= 1'b0;
            neg_res <= 1'b0;
            b_zero  <= 1'b0;
            O_QUOT  <= '0;
            O_DIV0  <= 1'b0;
            O_OVF   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (I_START) begin
                    cnt     <= '0;
                    num     <= N'(a_mag_in) << FRAC;
                    quot    <= '0;
                    rem     <= '0;
                    b_mag   <= b_mag_in;
                    neg_a   <= I_DIVIDEND[D_W-1];
                    neg_res <= I_DIVIDEND[D_W-1] ^ I_DIVISOR[D_W-1];
                    b_zero  <= (I_DIVISOR == '0);
                end
                CALC: begin
                    cnt  <= cnt + CW'(1);
                    num  <= num << 1;
                    rem  <= rem_ge ? rem_sub[D_W-1:0] : rem_sh[D_W-1:0];
                    quot <= {quot[N-2:0], rem_ge};
                end
                FIX: begin
                    O_QUOT <= q_fix;
                    O_DIV0 <= b_zero;
                    O_OVF  <= ovf_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_shift_seq.sv
// tb/tb_div_shift_seq.sv - self-checking bench for div_shift_seq with directed and random divisions
module tb_div_shift_seq;

    localparam int D_W  = 16;
    localparam int FRAC = 8;
    localparam int N    = D_W + FRAC;
    localparam int LAT  = N + 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [D_W-1:0] dividend = '0;
    logic [D_W-1:0] divisor = '0;
    logic           busy, valid, div0, ovf;
    logic [D_W-1:0] quot;

    int n_cmp = 0;
    int n_err = 0;

    div_shift_seq #(.D_W(D_W), .FRAC(FRAC)) dut (
        .I_CLK      (clk),
        .I_RST      (rst),
        .I_START    (start),
        .I_DIVIDEND (dividend),
        .I_DIVISOR  (divisor),
        .O_BUSY     (busy),
        .O_VALID    (valid),
        .O_QUOT     (quot),
        .O_DIV0     (div0),
        .O_OVF      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer division of the scaled magnitudes, then sign and limits
    task automatic ref_div(input logic [D_W-1:0] a, input logic [D_W-1:0] b,
                           output logic [D_W-1:0] q, output logic d0, output logic ov);
        longint av, bv, ma, mb, num, mag, r, lim_pos, lim_neg;
        logic neg;
        av = longint'($signed(a));
        bv = longint'($signed(b));
        lim_pos = (longint'(1) << (D_W - 1)) - 1;
        lim_neg = longint'(1) << (D_W - 1);
        d0 = 1'b0;
        ov = 1'b0;
        if (bv == 0) begin
            d0 = 1'b1;
            q  = (av < 0) ? D_W'(-lim_neg) : D_W'(lim_pos);
        end else begin
            ma  = (av < 0) ? -av : av;
            mb  = (bv < 0) ? -bv : bv;
            num = ma * (longint'(1) << FRAC);
            mag = num / mb;
            r   = num % mb;
`ifdef DIV_ROUND_EN
            if (2 * r >= mb) mag = mag + 1;
`endif
            neg = (av < 0) != (bv < 0);
            if (neg && mag > lim_neg) begin
                q = D_W'(-lim_neg); ov = 1'b1;
            end else if (!neg && mag > lim_pos) begin
                q = D_W'(lim_pos); ov = 1'b1;
            end else begin
                q = neg ? D_W'(-mag) : D_W'(mag);
            end
        end
    endtask

    // Start one division from IDLE and check latency, result, and single-cycle valid
    task automatic run_div(input string tag, input logic [D_W-1:0] a, input logic [D_W-1:0] b,
                           input logic [D_W-1:0] eq, input logic ed, input logic eo);
        int edges;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        while (!valid && edges < 4 * LAT) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, ".lat"}, 32'(edges), 32'(LAT));
        check({tag, ".quot"}, 32'(quot), 32'(eq));
        check({tag, ".div0"}, 32'(div0), 32'(ed));
        check({tag, ".ovf"}, 32'(ovf), 32'(eo));
        @(negedge clk);
        check({tag, ".pulse"}, 32'(valid), 32'd0);
    endtask

    initial begin
        logic [D_W-1:0] ra, rb, eq;
        logic ed, eo;
        int cyc, nval;

        #2;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.valid", 32'(valid), 32'd0);
        check("rst.quot", 32'(quot), 32'd0);
        check("rst.flags", 32'({div0, ovf}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_div("half",    16'h0100, 16'h0200, 16'h0080, 1'b0, 1'b0);
        run_div("neg1p5",  16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0);
`ifdef DIV_ROUND_EN
        run_div("twothird",16'h0200, 16'h0300, 16'h00AB, 1'b0, 1'b0);
`else
        run_div("twothird",16'h0200, 16'h0300, 16'h00AA, 1'b0, 1'b0);
`endif
        run_div("third",   16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0);
        run_div("div0p",   16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1'b0);
        run_div("div0n",   16'hFF00, 16'h0000, 16'h8000, 1'b1, 1'b0);
        run_div("div0z",   16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b0);
        run_div("ovfp",    16'h7F00, 16'h0080, 16'h7FFF, 1'b0, 1'b1);
        run_div("ovfmin",  16'h8000, 16'hFF00, 16'h7FFF, 1'b0, 1'b1);
        run_div("zeroneg", 16'h0000, 16'hFF00, 16'h0000, 1'b0, 1'b0);
        run_div("minexact",16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = D_W'($urandom);
            case (i % 4)
                0: rb = D_W'($urandom);
                1: rb = D_W'($urandom_range(0, 7)) - D_W'(3);
                2: rb = D_W'($urandom_range(0, 16'h01FF));
                default: rb = {D_W{1'b1}} - D_W'($urandom_range(0, 16'h03FF));
            endcase
            ref_div(ra, rb, eq, ed, eo);
            run_div($sformatf("rnd%0d", i), ra, rb, eq, ed, eo);
        end

        // Start while busy must neither disturb the result nor be queued
        @(negedge clk);
        dividend = 16'h0100;
        divisor  = 16'h0200;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        dividend = 16'h0700;
        divisor  = 16'h0100;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!valid && cyc < 4 * LAT) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_start.valid", 32'(valid), 32'd1);
        check("busy_start.quot", 32'(quot), 32'h0080);
        nval = 0;
        for (int k = 0; k < 2 * LAT; k++) begin
            @(negedge clk);
            if (valid) nval++;
        end
        check("busy_start.noqueue", 32'(nval), 32'd0);

        // Asynchronous reset mid-division clears everything at once
        @(negedge clk);
        dividend = 16'hFD00;
        divisor  = 16'h0200;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.valid", 32'(valid), 32'd0);
        check("midrst.quot", 32'(quot), 32'd0);
        check("midrst.flags", 32'({div0, ovf}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div("after_rst", 16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
